seg_scan_decoder: RTL

//  Receive-side counterpart of the stopwatch display driver: samples multiplexed 7-seg

---
 rtl/seg_scan_decoder.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder
//   Loopback monitor for a multiplexed 4-digit 7-segment display. It samples the
//   segment and active-low anode lines and waits until each scan position has been
//   stable for STABLE_CYCLES samples. It then decodes the glyph back to BCD and
//   collects four digits into a frame. A frame is offered to a consumer through a
//   valid/ack handshake.
//
// Ports
//   clk              system clock
//   reset            synchronous, active-high reset
//   seg_in[6:0]      segment lines A..G ([0]=A), high = lit
//   an_in[3:0]       digit selects, active-low, [3] = leftmost digit
//   frame_ack_in     consumer accepts the held frame
//   digits_out[15:0] {d3,d2,d1,d0} BCD nibbles, 4'hF = blank / undecodable
//   blank_out[3:0]   per digit: glyph had no segments lit
//   digit_err_out[3:0] per digit: glyph not in the decode table
//   frame_valid_out  a frame is held on the outputs
//   overflow_out     sticky: held frame replaced before it was acknowledged
//   multi_sel_out    sticky: a stable pattern had more than one anode low
//   timeout_out      no frame completed within FRAME_TIMEOUT cycles
module seg_scan_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int FRAME_TIMEOUT = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [6:0]  seg_in,
  input  logic [3:0]  an_in,
  input  logic        frame_ack_in,
  output logic [15:0] digits_out,
  output logic [3:0]  blank_out,
  output logic [3:0]  digit_err_out,
  output logic        frame_valid_out,
  output logic        overflow_out,
  output logic        multi_sel_out,
  output logic        timeout_out
);

  localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(FRAME_TIMEOUT);
  localparam logic [CNT_W-1:0] STABLE_MAX = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] STABLE_PRE = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(FRAME_TIMEOUT - 1);

  typedef enum logic {IDLE, HOLD} state_t;

  // Staged digit layout: [5] = error, [4] = blank, [3:0] = BCD nibble
  function automatic logic [5:0] decode_glyph(input logic [6:0] seg);
    logic [5:0] res;
    res = 6'b10_1111;
    case (seg)
      7'h3F: res = 6'h00;
      7'h06: res = 6'h01;
      7'h5B: res = 6'h02;
      7'h4F: res = 6'h03;
      7'h66: res = 6'h04;
      7'h6D: res = 6'h05;
      7'h7D: res = 6'h06;
      7'h07: res = 6'h07;
      7'h7F: res = 6'h08;
      7'h6F: res = 6'h09;
      7'h00: res = 6'b01_1111;
      default: res = 6'b10_1111;
    endcase
    return res;
  endfunction

  logic [10:0]      sample_q;
  logic [CNT_W-1:0] stable_cnt;
  logic             strobe_q;
  logic [3:0][5:0]  stage_q;
  logic [3:0][5:0]  stage_next;
  logic [3:0]       mask_q;
  logic [3:0]       mask_next;
  logic [TO_W-1:0]  to_cnt;
  logic [1:0]       slot;
  logic             slot_hit;
  logic             multi_hit;
  logic             capture;
  logic             complete;
  logic             timeout_hit;
  state_t           state;

  wire [10:0] sample_now = {an_in, seg_in};
  wire        same       = (sample_now == sample_q);

  // Stability filter: the strobe is a one-cycle pulse issued on the edge where
  // the run of identical samples reaches STABLE_CYCLES. The counter then
  // saturates, so a held pattern never strobes twice.
  always_ff @(posedge clk) begin
    if (reset) begin
      sample_q   <= '0;
      stable_cnt <= '0;
      strobe_q   <= 1'b0;
    end else begin
      sample_q <= sample_now;
      strobe_q <= 1'b0;
      if (same) begin
        if (stable_cnt < STABLE_MAX) stable_cnt <= stable_cnt + 1'b1;
        if (stable_cnt == STABLE_PRE) strobe_q <= 1'b1;
      end else begin
        stable_cnt <= CNT_W'(1);
      end
    end
  end

  // Slot selection from the stable anode pattern. All-high is a blanking gap
  // and is ignored; any other pattern with more than one anode low is a fault.
  always_comb begin
    slot      = 2'd0;
    slot_hit  = 1'b0;
    multi_hit = 1'b0;
    case (sample_q[10:7])
      4'b1110: begin slot = 2'd0; slot_hit = 1'b1; end
      4'b1101: begin slot = 2'd1; slot_hit = 1'b1; end
      4'b1011: begin slot = 2'd2; slot_hit = 1'b1; end
      4'b0111: begin slot = 2'd3; slot_hit = 1'b1; end
      4'b1111: ;
      default: multi_hit = 1'b1;
    endcase
  end

  // Next staging contents and mask. A frame completes on the capture that fills
  // the last missing slot. The outputs then load from stage_next, which gives a
  // latency of one clock after the strobe.
  always_comb begin
    stage_next = stage_q;
    mask_next  = mask_q;
    capture    = strobe_q && slot_hit;
    if (capture) begin
      stage_next[slot] = decode_glyph(sample_q[6:0]);
      mask_next[slot]  = 1'b1;
    end
    complete    = capture && (mask_next == 4'hF);
    timeout_hit = (to_cnt == TO_LAST);
  end

  // Staging registers and capture mask. The mask restarts after each frame and
  // after a timeout, so a stale partial frame is never combined with new digits.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_q <= '0;
      mask_q  <= '0;
    end else begin
      stage_q <= stage_next;
      if (complete || timeout_hit) mask_q <= '0;
      else                         mask_q <= mask_next;
    end
  end

  // Frame watchdog. A completed frame restarts the count and clears the flag.
  // Reaching the limit raises the flag and starts a fresh window.
  always_ff @(posedge clk) begin
    if (reset) begin
      to_cnt      <= '0;
      timeout_out <= 1'b0;
    end else if (complete) begin
      to_cnt      <= '0;
      timeout_out <= 1'b0;
    end else if (timeout_hit) begin
      to_cnt      <= '0;
      timeout_out <= 1'b1;
    end else begin
      to_cnt <= to_cnt + 1'b1;
    end
  end

  // Sticky flag for a stable multi-anode pattern.
  always_ff @(posedge clk) begin
    if (reset)                       multi_sel_out <= 1'b0;
    else if (strobe_q && multi_hit)  multi_sel_out <= 1'b1;
  end

  // Handshake FSM. A completion always loads new data, even while a frame is
  // held. Doing so without an ack in the same cycle counts as an overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      digits_out      <= 16'h0000;
      blank_out       <= 4'h0;
      digit_err_out   <= 4'h0;
      frame_valid_out <= 1'b0;
      overflow_out    <= 1'b0;
    end else begin
      if (complete) begin
        for (int k = 0; k < 4; k++) begin
          digits_out[4*k +: 4] <= stage_next[k][3:0];
          blank_out[k]         <= stage_next[k][4];
          digit_err_out[k]     <= stage_next[k][5];
        end
      end
      case (state)
        IDLE: begin
          if (complete) begin
            state           <= HOLD;
            frame_valid_out <= 1'b1;
          end
        end
        HOLD: begin
          if (complete) begin
            if (!frame_ack_in) overflow_out <= 1'b1;
          end else if (frame_ack_in) begin
            state           <= IDLE;
            frame_valid_out <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
